// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
//   ctrl_state_t : sequencer states
//   REG_ZERO     : x0, never a real dependency
//   pipe_ctrl_t  : bundle of pipeline register controls
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      DRAIN    = 2'd2,
      HALTED   = 2'd3
   } ctrl_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic pc_write;
      logic pc_sel;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_write;
      logic id_ex_bubble;
      logic ex_mem_write;
      logic mem_wb_bubble;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t CTRL_DEFAULT = '{
      pc_write:      1'b1,
      pc_sel:        1'b0,
      if_id_write:   1'b1,
      if_id_flush:   1'b0,
      id_ex_write:   1'b1,
      id_ex_bubble:  1'b0,
      ex_mem_write:  1'b1,
      mem_wb_bubble: 1'b0
   };

   function automatic logic is_load_use(input logic       ex_mem_read,
                                        input logic [4:0] ex_rd,
                                        input logic [4:0] id_rs1,
                                        input logic [4:0] id_rs2);
      return ex_mem_read && (ex_rd != REG_ZERO) &&
             ((ex_rd == id_rs1) || (ex_rd == id_rs2));
   endfunction

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter.
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : count this cycle
//   clear      : restart from zero (clear with inc loads 1)
//   cnt        : current count, holds at all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= inc ? W'(1) : '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencer for the 5-stage core: load-use bubbles, taken-branch
// flushes, data-memory wait states and halt/drain.
//   clk, rst_n                      : clock, synchronous active-low reset
//   ID_EX_*/IF_ID_*                 : operands for load-use detection
//   branch_taken                    : EX resolved a taken branch/jump
//   EX_MEM_MemRead/MemWrite, dmem_ready : data memory access status
//   halt_req                        : level halt request
//   PC_Write..MEM_WB_Bubble, pc_sel : pipeline register controls (comb.)
//   dmem_req, halted, mem_timeout   : status
//   stall_cnt, flush_cnt            : saturating event counters
//
// state    | meaning
// RUN      | normal flow, events resolved by priority
// MEM_WAIT | pipeline frozen on an outstanding data access
// DRAIN    | fetch suppressed, NOPs injected for DRAIN_CYCLES
// HALTED   | core idle until halt_req drops
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int DRAIN_CYCLES = 4,
   parameter int MEM_TIMEOUT  = 64,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_Rd,
   input  logic [4:0]       IF_ID_Rs1,
   input  logic [4:0]       IF_ID_Rs2,
   input  logic             branch_taken,
   input  logic             EX_MEM_MemRead,
   input  logic             EX_MEM_MemWrite,
   input  logic             dmem_ready,
   input  logic             halt_req,
   output logic             PC_Write,
   output logic             pc_sel,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Write,
   output logic             ID_EX_Bubble,
   output logic             EX_MEM_Write,
   output logic             MEM_WB_Bubble,
   output logic             dmem_req,
   output logic             halted,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   ctrl_state_t state;
   pipe_ctrl_t  ctrl;
   logic [3:0]  drain_cnt;
   logic [7:0]  wait_cnt;
   logic        mem_stall;
   logic        load_use;
   logic        load_use_stall;
   logic        branch_flush;
   logic        wait_inc;
   logic        wait_clear;

   assign dmem_req  = EX_MEM_MemRead | EX_MEM_MemWrite;
   assign mem_stall = dmem_req & ~dmem_ready;
   assign load_use  = is_load_use(ID_EX_MemRead, ID_EX_Rd, IF_ID_Rs1, IF_ID_Rs2);

   // A pending data access freezes everything in every state; branch and
   // load-use are simply re-evaluated once the access completes.
   always_comb begin
      ctrl           = CTRL_DEFAULT;
      load_use_stall = 1'b0;
      branch_flush   = 1'b0;
      if (!rst_n) begin
         ctrl = CTRL_DEFAULT;
      end else if (mem_stall) begin
         ctrl.pc_write      = 1'b0;
         ctrl.if_id_write   = 1'b0;
         ctrl.id_ex_write   = 1'b0;
         ctrl.ex_mem_write  = 1'b0;
         ctrl.mem_wb_bubble = 1'b1;
      end else if (state == HALTED) begin
         ctrl.pc_write    = 1'b0;
         ctrl.if_id_write = 1'b0;
         ctrl.if_id_flush = 1'b1;
      end else begin
         if (state == DRAIN) begin
            ctrl.pc_write    = 1'b0;
            ctrl.if_id_flush = 1'b1;
         end
         if (branch_taken) begin
            ctrl.pc_sel       = 1'b1;
            ctrl.pc_write     = 1'b1;
            ctrl.if_id_flush  = 1'b1;
            ctrl.id_ex_bubble = 1'b1;
            branch_flush      = 1'b1;
         end else if (load_use) begin
            ctrl.pc_write     = 1'b0;
            ctrl.if_id_write  = 1'b0;
            ctrl.id_ex_bubble = 1'b1;
            load_use_stall    = 1'b1;
         end
      end
   end

   assign PC_Write      = ctrl.pc_write;
   assign pc_sel        = ctrl.pc_sel;
   assign IF_ID_Write   = ctrl.if_id_write;
   assign IF_ID_Flush   = ctrl.if_id_flush;
   assign ID_EX_Write   = ctrl.id_ex_write;
   assign ID_EX_Bubble  = ctrl.id_ex_bubble;
   assign EX_MEM_Write  = ctrl.ex_mem_write;
   assign MEM_WB_Bubble = ctrl.mem_wb_bubble;
   assign halted        = rst_n && (state == HALTED);

   // Entering MEM_WAIT restarts the wait count at 1 (clear together with inc).
   assign wait_clear = (state == RUN) && mem_stall;
   assign wait_inc   = mem_stall &&
                       ((state == RUN) ||
                        ((state == MEM_WAIT) && (wait_cnt != 8'(MEM_TIMEOUT))));

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (mem_stall | load_use_stall),
      .clear (1'b0),
      .cnt   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (branch_flush),
      .clear (1'b0),
      .cnt   (flush_cnt)
   );

   sat_counter #(.W(8)) u_wait_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (wait_inc),
      .clear (wait_clear),
      .cnt   (wait_cnt)
   );

   // drain_cnt is a down-counter loaded on entry; the last drain cycle is
   // the one where it reads 1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= RUN;
         drain_cnt   <= 4'd0;
         mem_timeout <= 1'b0;
      end else begin
         if (wait_inc && (state == MEM_WAIT) && (wait_cnt == 8'(MEM_TIMEOUT - 1))) begin
            mem_timeout <= 1'b1;
         end
         case (state)
            RUN: begin
               if (mem_stall) begin
                  state <= MEM_WAIT;
               end else if (halt_req) begin
                  state     <= DRAIN;
                  drain_cnt <= 4'(DRAIN_CYCLES);
               end
            end
            MEM_WAIT: begin
               if (!mem_stall) begin
                  if (halt_req) begin
                     state     <= DRAIN;
                     drain_cnt <= 4'(DRAIN_CYCLES);
                  end else begin
                     state <= RUN;
                  end
               end
            end
            DRAIN: begin
               if (!mem_stall) begin
                  if (drain_cnt <= 4'd1) begin
                     state <= HALTED;
                  end else begin
                     drain_cnt <= drain_cnt - 4'd1;
                  end
               end
            end
            HALTED: begin
               if (!halt_req) begin
                  state <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ID_EX_MemRead;
   logic [4:0]  ID_EX_Rd;
   logic [4:0]  IF_ID_Rs1;
   logic [4:0]  IF_ID_Rs2;
   logic        branch_taken;
   logic        EX_MEM_MemRead;
   logic        EX_MEM_MemWrite;
   logic        dmem_ready;
   logic        halt_req;
   logic        PC_Write, pc_sel, IF_ID_Write, IF_ID_Flush;
   logic        ID_EX_Write, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble;
   logic        dmem_req, halted, mem_timeout;
   logic [15:0] stall_cnt, flush_cnt;

   int checks   = 0;
   int failures = 0;

   hazard_ctrl_unit #(.DRAIN_CYCLES(4), .MEM_TIMEOUT(64), .CNT_W(16)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ID_EX_MemRead   (ID_EX_MemRead),
      .ID_EX_Rd        (ID_EX_Rd),
      .IF_ID_Rs1       (IF_ID_Rs1),
      .IF_ID_Rs2       (IF_ID_Rs2),
      .branch_taken    (branch_taken),
      .EX_MEM_MemRead  (EX_MEM_MemRead),
      .EX_MEM_MemWrite (EX_MEM_MemWrite),
      .dmem_ready      (dmem_ready),
      .halt_req        (halt_req),
      .PC_Write        (PC_Write),
      .pc_sel          (pc_sel),
      .IF_ID_Write     (IF_ID_Write),
      .IF_ID_Flush     (IF_ID_Flush),
      .ID_EX_Write     (ID_EX_Write),
      .ID_EX_Bubble    (ID_EX_Bubble),
      .EX_MEM_Write    (EX_MEM_Write),
      .MEM_WB_Bubble   (MEM_WB_Bubble),
      .dmem_req        (dmem_req),
      .halted          (halted),
      .mem_timeout     (mem_timeout),
      .stall_cnt       (stall_cnt),
      .flush_cnt       (flush_cnt)
   );

   always #5 clk = ~clk;

   // {PC_Write, pc_sel, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble,
   //  EX_MEM_Write, MEM_WB_Bubble, dmem_req}
   logic [8:0] act_ctrl;
   assign act_ctrl = {PC_Write, pc_sel, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                      ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble, dmem_req};

   localparam logic [8:0] E_DEF0 = 9'b101010100;
   localparam logic [8:0] E_DEF1 = 9'b101010101;
   localparam logic [8:0] E_FRZ  = 9'b000000011;
   localparam logic [8:0] E_BR0  = 9'b111111100;
   localparam logic [8:0] E_BR1  = 9'b111111101;
   localparam logic [8:0] E_LU0  = 9'b000011100;
   localparam logic [8:0] E_LU1  = 9'b000011101;
   localparam logic [8:0] E_DRN  = 9'b001110100;
   localparam logic [8:0] E_HLT  = 9'b000110100;

   typedef struct {
      logic       ld;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       br;
      logic       mrd;
      logic       mwr;
      logic       rdy;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ID_EX_MemRead   = 1'b0;
      ID_EX_Rd        = 5'd0;
      IF_ID_Rs1       = 5'd0;
      IF_ID_Rs2       = 5'd0;
      branch_taken    = 1'b0;
      EX_MEM_MemRead  = 1'b0;
      EX_MEM_MemWrite = 1'b0;
      dmem_ready      = 1'b1;
      halt_req        = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      ID_EX_MemRead   = v.ld;
      ID_EX_Rd        = v.rd;
      IF_ID_Rs1       = v.rs1;
      IF_ID_Rs2       = v.rs2;
      branch_taken    = v.br;
      EX_MEM_MemRead  = v.mrd;
      EX_MEM_MemWrite = v.mwr;
      dmem_ready      = v.rdy;
      halt_req        = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      //            ld    rd     rs1    rs2    br    mrd   mwr   rdy   exp
      vecs[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_DEF0};
      vecs[1]  = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, E_LU0};
      vecs[2]  = '{1'b1, 5'd5, 5'd5, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1, E_LU0};
      vecs[3]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_DEF0};
      vecs[4]  = '{1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, E_DEF0};
      vecs[5]  = '{1'b1, 5'd7, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1, E_DEF0};
      vecs[6]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, E_BR0};
      vecs[7]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, E_BR0};
      vecs[8]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_DEF1};
      vecs[9]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, E_FRZ};
      vecs[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, E_BR1};
      vecs[11] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ};
      vecs[12] = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, E_LU1};
      vecs[13] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, E_DEF0};

      // reset state
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_ctrl", 32'(act_ctrl), 32'(E_DEF0));
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_timeout", 32'(mem_timeout), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
      rst_n = 1'b1;

      // single-cycle priority table
      for (int i = 0; i < 14; i++) begin
         apply(vecs[i]);
         #1;
         chk($sformatf("vec%0d_ctrl", i), 32'(act_ctrl), 32'(vecs[i].exp));
         tick();
      end
      idle();
      #1;
      chk("table_stall_cnt", 32'(stall_cnt), 32'd5);
      chk("table_flush_cnt", 32'(flush_cnt), 32'd3);
      chk("table_timeout", 32'(mem_timeout), 32'd0);

      // store held off 3 cycles with a pending branch
      do_reset();
      EX_MEM_MemWrite = 1'b1;
      dmem_ready      = 1'b0;
      branch_taken    = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("store_wait%0d_ctrl", c), 32'(act_ctrl), 32'(E_FRZ));
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      chk("store_ready_ctrl", 32'(act_ctrl), 32'(E_BR1));
      tick();
      idle();
      #1;
      chk("store_stall_cnt", 32'(stall_cnt), 32'd3);
      chk("store_flush_cnt", 32'(flush_cnt), 32'd1);

      // memory timeout after 64 wait cycles
      EX_MEM_MemRead = 1'b1;
      dmem_ready     = 1'b0;
      for (int c = 1; c <= 64; c++) begin
         tick();
         if (c == 63) chk("timeout_c63", 32'(mem_timeout), 32'd0);
         if (c == 64) begin
            chk("timeout_c64", 32'(mem_timeout), 32'd1);
            chk("timeout_still_frozen", 32'(act_ctrl), 32'(E_FRZ));
         end
      end
      dmem_ready = 1'b1;
      #1;
      chk("timeout_ready_ctrl", 32'(act_ctrl), 32'(E_DEF1));
      tick();
      idle();
      #1;
      chk("timeout_sticky", 32'(mem_timeout), 32'd1);
      chk("timeout_stall_cnt", 32'(stall_cnt), 32'd67);
      chk("timeout_back_run", 32'(act_ctrl), 32'(E_DEF0));

      // halt pulse: 4 drain cycles then one halted cycle
      halt_req = 1'b1;
      #1;
      chk("halt_req_run_ctrl", 32'(act_ctrl), 32'(E_DEF0));
      tick();
      halt_req = 1'b0;
      for (int d = 1; d <= 4; d++) begin
         #1;
         chk($sformatf("drain%0d_ctrl", d), 32'(act_ctrl), 32'(E_DRN));
         chk($sformatf("drain%0d_halted", d), 32'(halted), 32'd0);
         tick();
      end
      chk("halted_set", 32'(halted), 32'd1);
      chk("halted_ctrl", 32'(act_ctrl), 32'(E_HLT));
      tick();
      chk("halt_release", 32'(halted), 32'd0);
      chk("halt_release_ctrl", 32'(act_ctrl), 32'(E_DEF0));

      // held halt with a branch during drain
      halt_req = 1'b1;
      tick();
      #1;
      chk("drainb1_ctrl", 32'(act_ctrl), 32'(E_DRN));
      tick();
      branch_taken = 1'b1;
      #1;
      chk("drainb2_branch_ctrl", 32'(act_ctrl), 32'(E_BR0));
      tick();
      branch_taken = 1'b0;
      tick();
      tick();
      chk("held_halted1", 32'(halted), 32'd1);
      tick();
      chk("held_halted2", 32'(halted), 32'd1);
      halt_req = 1'b0;
      tick();
      chk("held_release", 32'(halted), 32'd0);
      chk("drain_flush_cnt", 32'(flush_cnt), 32'd2);

      // reset in the middle of a drain
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      #1;
      chk("rstdrain_pre_ctrl", 32'(act_ctrl), 32'(E_DRN));
      rst_n = 1'b0;
      #1;
      chk("rstdrain_same_cycle", 32'(act_ctrl), 32'(E_DEF0));
      tick();
      chk("rstdrain_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rstdrain_flush_cnt", 32'(flush_cnt), 32'd0);
      chk("rstdrain_timeout", 32'(mem_timeout), 32'd0);
      rst_n = 1'b1;
      tick();
      #1;
      chk("rstdrain_run_ctrl", 32'(act_ctrl), 32'(E_DEF0));
      chk("rstdrain_halted", 32'(halted), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Central pipeline sequencer for the 5-stage core. It works alongside the forwarding logic and covers the cases forwarding cannot resolve: load-use bubbles, taken-branch flushes, data-memory wait states and a halt/drain sequence. It drives the write enables, flushes and bubble selects of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also keeps saturating stall and flush counters and a sticky memory-timeout flag.

Parameters:
DRAIN_CYCLES, 4, cycles of fetch suppression before entering HALTED (1..15)
MEM_TIMEOUT, 64, MEM_WAIT cycles before mem_timeout sets (2..255)
CNT_W, 16, width of the stall and flush counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
ID_EX_MemRead  in  1  the instruction in EX is a load
ID_EX_Rd  in  5  destination register of the instruction in EX
IF_ID_Rs1  in  5  rs1 of the instruction in ID
IF_ID_Rs2  in  5  rs2 of the instruction in ID
branch_taken  in  1  EX resolved a taken branch or jump
EX_MEM_MemRead  in  1  the instruction in MEM is a load
EX_MEM_MemWrite  in  1  the instruction in MEM is a store
dmem_ready  in  1  data memory completes the access this cycle
halt_req  in  1  level request to halt the core
PC_Write  out  1  PC register enable
pc_sel  out  1  1 = PC loads the branch target
IF_ID_Write  out  1  IF/ID enable
IF_ID_Flush  out  1  IF/ID loads a NOP
ID_EX_Write  out  1  ID/EX enable
ID_EX_Bubble  out  1  ID/EX loads a NOP (control bits zeroed)
EX_MEM_Write  out  1  EX/MEM enable
MEM_WB_Bubble  out  1  MEM/WB loads a NOP
dmem_req  out  1  data memory request
halted  out  1  core is halted
mem_timeout  out  1  sticky flag: memory access timed out
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of branch flushes

Behaviour:
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED. Reset state is RUN.
- Control outputs are combinational from the state and the current inputs. The state, the counters and mem_timeout are registered.
- Reset values:
  - PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write = 1.
  - All flush/bubble outputs, pc_sel, halted, mem_timeout = 0.
  - Counters = 0. Drain and wait counters = 0.
- Default (no event): all write enables = 1, all flush/bubble outputs = 0.
- dmem_req = EX_MEM_MemRead | EX_MEM_MemWrite in every state.
- mem_stall = dmem_req & !dmem_ready.
- Event priority, applied within one cycle (highest first):
  1. mem_stall: all enables = 0, MEM_WB_Bubble = 1. No other event acts, so branch_taken and any load-use are held and re-evaluated when the pipeline advances.
  2. branch_taken: pc_sel = 1, PC_Write = 1, IF_ID_Flush = 1, ID_EX_Bubble = 1. Any coincident load-use is suppressed.
  3. load-use (ID_EX_MemRead & ID_EX_Rd != 0 & (ID_EX_Rd == IF_ID_Rs1 | ID_EX_Rd == IF_ID_Rs2)): PC_Write = 0, IF_ID_Write = 0, ID_EX_Bubble = 1.
- RUN transitions:
  - mem_stall → MEM_WAIT (wait counter = 1).
  - Otherwise halt_req → DRAIN (drain counter = 0).
  - Otherwise stay in RUN.
- MEM_WAIT:
  - The freeze holds while !dmem_ready. The wait counter increments, saturating at MEM_TIMEOUT.
  - mem_timeout sets when the counter reaches MEM_TIMEOUT. It clears only on reset. The FSM keeps waiting.
  - dmem_ready → freeze released in the same cycle; next state is RUN, or DRAIN if halt_req = 1.
- DRAIN:
  - PC_Write = 0 and IF_ID_Flush = 1 each cycle (NOPs injected).
  - branch_taken still sets pc_sel = 1 and PC_Write = 1 so the resume PC is correct.
  - The drain counter increments only when there is no mem_stall.
  - At DRAIN_CYCLES → HALTED. Deasserting halt_req mid-drain does not abort the drain.
- HALTED:
  - halted = 1, PC_Write = 0, IF_ID_Write = 0, IF_ID_Flush = 1.
  - halt_req = 0 → RUN on the next edge; halted drops with the state.
- Counters:
  - stall_cnt increments every cycle with mem_stall or a load-use stall.
  - flush_cnt increments once per cycle in which a branch flush is applied.
  - Both hold at 2^CNT_W − 1.
- Reset mid-operation: state returns to RUN, all registers take their reset values, and outputs revert to the default the same cycle.

Decomposition:
- Package hazard_pkg holds:
  - ctrl_state_t enum {RUN, MEM_WAIT, DRAIN, HALTED};
  - localparam REG_ZERO = 5'd0;
  - a struct bundling the pipeline control outputs.
- Sub-module sat_counter (parameter W, inputs inc and clear) is instantiated for stall_cnt, flush_cnt and the wait counter.

Test Plan:
- Load x5 in EX, ID reads x5 as rs2 → one cycle of PC_Write = 0, IF_ID_Write = 0, ID_EX_Bubble = 1; stall_cnt = 1.
- Load to x0, ID reads x0 → no stall; stall_cnt stays 0.
- branch_taken together with a load-use hazard → pc_sel = 1, IF_ID_Flush = 1, ID_EX_Bubble = 1, PC_Write = 1; flush_cnt = 1, stall_cnt = 0.
- Store in MEM with dmem_ready low for 3 cycles and branch_taken high → 3 frozen cycles (all enables 0, MEM_WB_Bubble = 1); flush applied on the ready cycle; stall_cnt = 3.
- dmem_ready held low for 64 cycles → mem_timeout = 1 at cycle 64 and stays set after ready returns.
- halt_req pulse in RUN → 4 DRAIN cycles with IF_ID_Flush = 1, then halted = 1; release → RUN next cycle.
- Assert rst_n = 0 in DRAIN → RUN, all enables 1 and counters 0 on the next edge.
